// File: rtl/compute_bus_initiator_if.sv
// Chip-select/read/write bus between the compute initiator and the four-register peripheral.
`timescale 1ns/1ps
interface compute_bus_initiator_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   logic              oChipSelect_n;
   logic              oWrite_n;
   logic              oRead_n;
   logic [ADDR_W-1:0] oAddress;
   logic [DATA_W-1:0] oData;
   logic [DATA_W-1:0] iData;

   modport master (
      output oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
      input  iData
   );

   modport slave (
      input  oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
      output iData
   );
endinterface

// File: rtl/compute_bus_initiator.sv
// Writes A/B/X to the compute peripheral, reads them back, reports rA*rX+rB and a readback mismatch flag.
// Latency 10 cycles start-to-done; no backpressure: the peripheral never stalls and iStart is sampled only between transactions.
`timescale 1ns/1ps
module compute_bus_initiator #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   compute_bus_initiator_if.master bus,
   input  logic                  iStart,
   input  logic [3:0]            iA,
   input  logic [3:0]            iB,
   input  logic [3:0]            iX,
   output logic                  oBusy,
   output logic                  oDone,
   output logic                  oMismatch,
   output logic [DATA_W-1:0]     oResult
);

   typedef enum logic [3:0] {
      IDLE, WR_A, WR_B, WR_X, RD_A, CAP_A, RD_B, CAP_B, RD_X, CAP_X, DONE
   } state_t;

   state_t            state;
   logic [3:0]        opA, opB, opX;
   logic [DATA_W-1:0] rA, rB, rX;
   logic [7:0]        sum;
   logic              mis;
   logic              startNow;

   function automatic logic [DATA_W-1:0] ext4(input logic [3:0] v);
      return {{(DATA_W-4){1'b0}}, v};
   endfunction

   always_comb begin
      sum = ({4'b0, rA[3:0]} * {4'b0, rX[3:0]}) + {4'b0, rB[3:0]};
      mis = (rA[3:0] != opA) || (rB[3:0] != opB) || (rX[3:0] != opX) ||
            (|rA[DATA_W-1:4]) || (|rB[DATA_W-1:4]) || (|rX[DATA_W-1:4]);
      // A held start chains straight out of DONE so the back-to-back period stays 10 cycles.
      startNow = iStart && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state             <= IDLE;
         opA               <= '0;
         opB               <= '0;
         opX               <= '0;
         rA                <= '0;
         rB                <= '0;
         rX                <= '0;
         bus.oChipSelect_n <= 1'b1;
         bus.oWrite_n      <= 1'b1;
         bus.oRead_n       <= 1'b1;
         bus.oAddress      <= '0;
         bus.oData         <= '0;
         oBusy             <= 1'b0;
         oDone             <= 1'b0;
         oMismatch         <= 1'b0;
         oResult           <= '0;
      end else begin
         bus.oChipSelect_n <= 1'b1;
         bus.oWrite_n      <= 1'b1;
         bus.oRead_n       <= 1'b1;
         bus.oAddress      <= '0;
         bus.oData         <= '0;
         oDone             <= 1'b0;
         case (state)
            IDLE: state <= IDLE;
            WR_A: begin
               state             <= WR_B;
               bus.oChipSelect_n <= 1'b0;
               bus.oWrite_n      <= 1'b0;
               bus.oAddress      <= ADDR_W'(1);
               bus.oData         <= ext4(opB);
            end
            WR_B: begin
               state             <= WR_X;
               bus.oChipSelect_n <= 1'b0;
               bus.oWrite_n      <= 1'b0;
               bus.oAddress      <= ADDR_W'(2);
               bus.oData         <= ext4(opX);
            end
            WR_X: begin
               state             <= RD_A;
               bus.oChipSelect_n <= 1'b0;
               bus.oRead_n       <= 1'b0;
               bus.oAddress      <= ADDR_W'(0);
            end
            RD_A: state <= CAP_A;
            CAP_A: begin
               rA                <= bus.iData;
               state             <= RD_B;
               bus.oChipSelect_n <= 1'b0;
               bus.oRead_n       <= 1'b0;
               bus.oAddress      <= ADDR_W'(1);
            end
            RD_B: state <= CAP_B;
            CAP_B: begin
               rB                <= bus.iData;
               state             <= RD_X;
               bus.oChipSelect_n <= 1'b0;
               bus.oRead_n       <= 1'b0;
               bus.oAddress      <= ADDR_W'(2);
            end
            RD_X: state <= CAP_X;
            CAP_X: begin
               rX    <= bus.iData;
               state <= DONE;
            end
            DONE: begin
               oResult   <= {{(DATA_W-8){1'b0}}, sum};
               oMismatch <= mis;
               oDone     <= 1'b1;
               oBusy     <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (startNow) begin
            opA               <= iA;
            opB               <= iB;
            opX               <= iX;
            state             <= WR_A;
            oBusy             <= 1'b1;
            bus.oChipSelect_n <= 1'b0;
            bus.oWrite_n      <= 1'b0;
            bus.oAddress      <= ADDR_W'(0);
            bus.oData         <= ext4(iA);
         end
      end
   end

endmodule

// File: doc/compute_bus_initiator.md
# compute_bus_initiator

Avalon-style memory-mapped bus initiator that drives the four-register compute peripheral (operand A at address 0, operand B at address 1, operand X at address 2, each holding 4 bits). On a start request it writes the three operands, reads each one back, checks the readback, and reports A*X+B computed from the read-back values. It sits between a local controller (test sequencer or FSM) and the peripheral's chip-select/read/write slave port.

## Interface
Parameters:
- DATA_W, 32, bus data width
- ADDR_W, 2, bus address width

Ports:
- iClk  in  1  system clock, all logic on rising edge
- iReset_n  in  1  asynchronous active-low reset
- iStart  in  1  start request, sampled only in IDLE
- iA, iB, iX  in  4 each  operands to send
- oChipSelect_n  out  1  bus chip select, active low
- oWrite_n  out  1  bus write strobe, active low
- oRead_n  out  1  bus read strobe, active low
- oAddress  out  ADDR_W  bus address
- oData  out  DATA_W  bus write data, {28'b0, operand}
- iData  in  DATA_W  bus read data from peripheral
- oBusy  out  1  transaction in progress
- oDone  out  1  one-cycle completion pulse
- oMismatch  out  1  readback check failed, valid with oDone, held until next oDone
- oResult  out  DATA_W  rA*rX+rB, zero-extended, held until next oDone

## Operation
- All outputs registered. Reset values: oChipSelect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, oData=0, oBusy=0, oDone=0, oMismatch=0, oResult=0; state IDLE; operand and readback registers 0.
- Bus idle means chip select, write and read strobes all 1, address 0, data 0.
- States: IDLE, WR_A, WR_B, WR_X, RD_A, CAP_A, RD_B, CAP_B, RD_X, CAP_X, DONE. Each non-IDLE state lasts exactly one cycle. There is no wait-request, and the peripheral never stalls.
- IDLE: when iStart=1, latch iA/iB/iX and go to WR_A. Otherwise hold.
- WR_n: chip select=0, write strobe=0, address 0/1/2, data = latched operand zero-extended.
- RD_n: chip select=0, read strobe=0, address 0/1/2.
- CAP_n: bus idle. At the end of CAP_n, iData is captured into readback register rA/rB/rX.
- Peripheral read latency is 1: it registers read data on the edge that ends RD_n. That data is sampled on the edge that ends CAP_n.
- DONE: bus idle. At the exit edge:
  - oResult <= rA[3:0]*rX[3:0]+rB[3:0], 8-bit value (max 240), zero-extended.
  - oMismatch <= 1 if any readback[3:0] differs from the written operand, or any readback[DATA_W-1:4] is nonzero.
  - oDone <= 1; return to IDLE.
- oDone is cleared on the following edge.
- iStart is ignored while not in IDLE. If iStart is held high, a new transaction begins immediately on return to IDLE.
- Reset mid-transaction aborts asynchronously: all registers take reset values and the bus goes idle immediately. No partial oDone is issued.

## Timing
Edge 0 is the edge that samples iStart=1 in IDLE.
- Edges 0/1/2 enter WR_A/WR_B/WR_X. The peripheral captures A/B/X at edges 1/2/3.
- Edge 3 enters RD_A, edge 4 CAP_A, edge 5 RD_B (captures rA), edge 6 CAP_B, edge 7 RD_X (captures rB), edge 8 CAP_X.
- Edge 9 captures rX and enters DONE.
- Edge 10: IDLE, with oDone=1 and oResult/oMismatch updated. Edge 11: oDone=0.
- oBusy=1 from edge 0 through edge 10, i.e. while state is not IDLE. It falls at edge 10.
- Start-to-done latency: 10 cycles. Back-to-back period: 10 cycles. Exactly 3 write cycles and 3 read cycles per transaction.

## Test plan
- A=3, B=5, X=7 with a behavioural peripheral model. Expect:
  - writes at addresses 0,1,2 with data 3,5,7 in cycles 0–2;
  - reads at addresses 0,1,2 in cycles 3, 5, 7;
  - oDone at edge 10, oResult=26, oMismatch=0.
- A=15, B=15, X=15 -> oResult=240, oMismatch=0 (width boundary).
- Peripheral model corrupts the readback of B to 4 -> oMismatch=1, oResult=A*X+4. Repeat with upper bit 31 set in the readback of X -> oMismatch=1.
- iStart pulses in cycles 2 and 6 of a running transaction -> ignored: single oDone, exactly 3 writes and 3 reads. iStart held high for 25 cycles -> oDone at edges 10 and 20, and a third transaction is busy.
- iReset_n asserted during RD_B -> bus idle and all outputs at reset values immediately. After release, the next start completes normally with the new operands.
- After reset with no start -> bus stays idle, and oBusy/oDone/oResult stay 0 for 50 cycles.
